// File: rtl/pipe_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_queue_pkg
// Purpose  : Shared pipeline constants: stage bundle width, bubble value and
//            bundle field layout used by every stage register and queue.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_queue_pkg;

  localparam int DATA_W = 41;

  // Bundle layout: {valid, opcode[7:0], pc[31:0]}
  localparam int VALID_BIT = 40;
  localparam int OPC_LSB   = 32;
  localparam int OPC_W     = 8;
  localparam int PC_LSB    = 0;
  localparam int PC_W      = 32;

  localparam logic [DATA_W-1:0] BUBBLE = '0;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [PC_W-1:0]   pc;
  } stage_bundle_t;

  function automatic logic bundle_valid(input logic [DATA_W-1:0] b);
    return b[VALID_BIT];
  endfunction

  function automatic logic [OPC_W-1:0] bundle_opcode(input logic [DATA_W-1:0] b);
    return b[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [PC_W-1:0] bundle_pc(input logic [DATA_W-1:0] b);
    return b[PC_LSB +: PC_W];
  endfunction

  function automatic logic [DATA_W-1:0] make_bundle(input logic [OPC_W-1:0] opc,
                                                    input logic [PC_W-1:0]  pc);
    stage_bundle_t s;
    s.valid  = 1'b1;
    s.opcode = opc;
    s.pc     = pc;
    return s;
  endfunction

endpackage : pipe_queue_pkg
`default_nettype wire

// File: rtl/pipe_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : pipe_queue_ptr
// Purpose  : Modulo-DEPTH pointer with increment and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_queue_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow of PTR_W bits is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : pipe_queue_ptr
`default_nettype wire

// File: rtl/pipe_queue.sv
`default_nettype none
// ============================================================================
// Module   : pipe_queue
// Purpose  : Multi-entry elastic queue between two pipeline stages with
//            first-word fall-through head, status flags and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_queue
  import pipe_queue_pkg::*;
#(
  parameter  int DATA_W = pipe_queue_pkg::DATA_W,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              wr_drop
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;
  logic              wr_drop_q;
  logic              wr_drop_d;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push_ok;
  logic              pop_ok;
  logic              wr_inc;
  logic              rd_inc;

  // Flags come from the registered count so full and empty are unambiguous
  // even when the two pointers are equal.
  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign rd_valid = ~empty;
  assign count    = count_q;
  assign wr_drop  = wr_drop_q;

  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);

  assign wr_inc = push_ok & ~flush;
  assign rd_inc = pop_ok  & ~flush;

  pipe_queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (wr_inc),
    .ptr_o (wr_ptr)
  );

  pipe_queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (rd_inc),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d   = count_q;
    wr_drop_d = 1'b0;
    if (flush) begin
      count_d = '0;
    end else begin
      if (wr_inc && !rd_inc) begin
        count_d = count_q + (PTR_W+1)'(1);
      end else if (rd_inc && !wr_inc) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
      wr_drop_d = wr_en & ~push_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage needs no reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (wr_inc) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = empty ? BUBBLE : mem_q[rd_ptr];

endmodule : pipe_queue
`default_nettype wire

// File: tb/tb_pipe_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_queue
// Purpose  : Directed self-checking bench for pipe_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_queue;

  localparam int DW = 41;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          wr_drop;

  int n_checks = 0;
  int n_err    = 0;

  pipe_queue dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] model[$];
  int            pushed;
  int            popped;
  logic          w;
  logic          r;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_full",     64'(full),     64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data",  64'(rd_data),  64'd0);
    chk("rst_wr_drop",  64'(wr_drop),  64'd0);
    rst = 1'b0;
    cyc();

    // Fill
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      cyc();
      chk("fill_count", 64'(count),   64'(i));
      chk("fill_head",  64'(rd_data), 64'd1);
      chk("fill_full",  64'(full),    (i == 4) ? 64'd1 : 64'd0);
    end

    // Overflow: push rejected, one-cycle drop pulse
    drive(1'b1, 41'h1FF_FFFF_FFFF, 1'b0, 1'b0);
    cyc();
    chk("ovf_drop",  64'(wr_drop), 64'd1);
    chk("ovf_count", 64'(count),   64'd4);
    chk("ovf_head",  64'(rd_data), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("ovf_drop_clr", 64'(wr_drop), 64'd0);

    // Push and pop while full
    drive(1'b1, DW'(5), 1'b1, 1'b0);
    cyc();
    chk("fpp_count", 64'(count),   64'd4);
    chk("fpp_full",  64'(full),    64'd1);
    chk("fpp_head",  64'(rd_data), 64'd2);
    chk("fpp_drop",  64'(wr_drop), 64'd0);

    // Drain: 2,3,4,5 in order
    for (int i = 2; i <= 5; i++) begin
      chk("drain_head", 64'(rd_data), 64'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
      cyc();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", 64'(empty),   64'd1);
    chk("drain_data",  64'(rd_data), 64'd0);

    // Pop while empty is ignored
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    chk("underflow_count", 64'(count), 64'd0);
    drive(1'b1, DW'('hA), 1'b0, 1'b0);
    cyc();
    chk("after_uf_head", 64'(rd_data), 64'hA);
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    chk("after_uf_empty", 64'(empty), 64'd1);

    // Wrap: occupancy kept between 1 and 3, checked against a reference queue
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 60 && popped < 10; i++) begin
      w = (pushed < 10) && (model.size() < 3);
      r = (model.size() > 0) && ((model.size() == 3) || (i % 2 == 1) || (pushed == 10));
      if (model.size() > 0) chk("wrap_head", 64'(rd_data), 64'(model[0]));
      drive(w, DW'(41'h100_0000_0000 + pushed), r, 1'b0);
      cyc();
      if (r) begin
        void'(model.pop_front());
        popped++;
      end
      if (w) begin
        model.push_back(DW'(41'h100_0000_0000 + pushed));
        pushed++;
      end
      chk("wrap_count", 64'(count),   64'(model.size()));
      chk("wrap_drop",  64'(wr_drop), 64'd0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_done_empty", 64'(empty), (popped == 10) ? 64'd1 : 64'd0);
    if (popped != 10) chk("wrap_budget", 64'(popped), 64'd10);

    // Flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
      cyc();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, DW'(7), 1'b1, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", 64'(count),   64'd0);
    chk("flush_empty", 64'(empty),   64'd1);
    chk("flush_data",  64'(rd_data), 64'd0);
    chk("flush_drop",  64'(wr_drop), 64'd0);
    cyc();
    chk("flush_no7", 64'(empty), 64'd1);

    // Flush while full with a push: no drop pulse
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(i + 1), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b1, DW'(9), 1'b0, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_full_drop",  64'(wr_drop), 64'd0);
    chk("flush_full_count", 64'(count),   64'd0);

    // Asynchronous reset mid-cycle with 3 entries
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(8'h21 + i), 1'b0, 1'b0);
      cyc();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count),   64'd0);
    chk("arst_empty", 64'(empty),   64'd1);
    chk("arst_data",  64'(rd_data), 64'd0);
    cyc();
    rst = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("arst_pop_count", 64'(count),    64'd0);
    chk("arst_pop_valid", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_pipe_queue
`default_nettype wire
